// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_REQ requesters.
// One registered issue per cycle; read data returns RD_LATENCY+1 cycles after issue.
module mem_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      mem_wr_en,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               mem_wr_en_q, mem_wr_en_d;
  logic               mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   issue_idx_q, issue_idx_d;

  logic [RD_LATENCY-1:0] tag_vld_q;
  logic [IDX_W-1:0]      tag_idx_q [RD_LATENCY];

  logic [NUM_REQ-1:0] elig;
  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W:0]     cand;

  // Last cycle's grantee is masked so nobody is issued twice in a row.
  always_comb begin
    elig    = req & ~gnt_q;
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!win_vld && elig[cand[IDX_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    gnt_d       = '0;
    mem_wr_en_d = 1'b0;
    mem_rd_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ptr_d       = ptr_q;
    issue_idx_d = issue_idx_q;
    if (win_vld) begin
      gnt_d[win_idx] = 1'b1;
      mem_wr_en_d    = req_we[win_idx];
      mem_rd_en_d    = ~req_we[win_idx];
      mem_addr_d     = addr_arr[win_idx];
      mem_wdata_d    = wdata_arr[win_idx];
      issue_idx_d    = win_idx;
      ptr_d          = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
    end
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    if (tag_vld_q[RD_LATENCY-1]) begin
      rsp_valid_d[tag_idx_q[RD_LATENCY-1]] = 1'b1;
      rsp_rdata_d                          = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      mem_wr_en_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ptr_q       <= '0;
      issue_idx_q <= '0;
      tag_vld_q   <= '0;
      for (int s = 0; s < RD_LATENCY; s++) tag_idx_q[s] <= '0;
    end else begin
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ptr_q       <= ptr_d;
      issue_idx_q <= issue_idx_d;
      // Stage 0 is loaded while the read strobe is on the memory port.
      tag_vld_q[0] <= mem_rd_en_q;
      tag_idx_q[0] <= issue_idx_q;
      for (int s = 1; s < RD_LATENCY; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_idx_q[s] <= tag_idx_q[s-1];
      end
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with a write-first, 1-cycle-latency memory model.
module tb_mem_rr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 2;
  localparam int DATA_W  = 8;

  logic                      clk;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      mem_wr_en;
  logic                      mem_rd_en;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;

  logic [DATA_W-1:0] mem [4];
  int checks;
  int failures;

  mem_rr_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(1)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_wr_en(mem_wr_en),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    req[i]                       = 1'b1;
    req_we[i]                    = we;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    req    = '0;
    req_we = '0;
    step();
    step();
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0000", rsp_valid); end
    checks++; if ({mem_wr_en, mem_rd_en} !== 2'b00) begin failures++; $display("FAIL rst_strobes got=%b exp=00", {mem_wr_en, mem_rd_en}); end
    checks++; if ({mem_addr, mem_wdata, rsp_rdata} !== 18'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", {mem_addr, mem_wdata, rsp_rdata}); end
  endtask

  task automatic test_write_read();
    set_req(0, 1'b1, 2'd2, 8'hA5);
    step();
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL t1_wr_gnt got=%b exp=0001", gnt); end
    checks++; if ({mem_wr_en, mem_rd_en, mem_addr, mem_wdata} !== {1'b1, 1'b0, 2'd2, 8'hA5}) begin
      failures++; $display("FAIL t1_wr_port got=%b%b %h %h exp=10 2 a5", mem_wr_en, mem_rd_en, mem_addr, mem_wdata); end
    req[0] = 1'b0;
    step();
    set_req(0, 1'b0, 2'd2, 8'h00);
    step();
    checks++; if ({gnt, mem_rd_en, mem_wr_en, mem_addr} !== {4'b0001, 1'b1, 1'b0, 2'd2}) begin
      failures++; $display("FAIL t1_rd_issue got=%b %b%b %h exp=0001 10 2", gnt, mem_rd_en, mem_wr_en, mem_addr); end
    req[0] = 1'b0;
    step();
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL t1_rsp_early got=%b exp=0000", rsp_valid); end
    step();
    checks++; if (rsp_valid !== 4'b0001 || rsp_rdata !== 8'hA5) begin
      failures++; $display("FAIL t1_rsp got=%b/%h exp=0001/a5", rsp_valid, rsp_rdata); end
    step();
    checks++; if (rsp_valid !== 4'b0000 || rsp_rdata !== 8'hA5) begin
      failures++; $display("FAIL t1_rsp_hold got=%b/%h exp=0000/a5", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_all_request();
    logic [NUM_REQ-1:0] exp;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, ADDR_W'(i), DATA_W'(8'h40 + i));
    for (int k = 0; k < 8; k++) begin
      step();
      exp = 4'b0001 << (k % 4);
      checks++; if (gnt !== exp || mem_wr_en !== 1'b1) begin
        failures++; $display("FAIL t2_rr_%0d got=%b wr=%b exp=%b wr=1", k, gnt, mem_wr_en, exp); end
    end
    req = '0;
    step();
    step();
  endtask

  task automatic test_single_requester();
    logic [NUM_REQ-1:0] exp;
    do_reset();
    set_req(2, 1'b0, 2'd0, 8'h00);
    for (int k = 0; k < 6; k++) begin
      step();
      exp = (k % 2 == 0) ? 4'b0100 : 4'b0000;
      checks++; if (gnt !== exp || mem_rd_en !== exp[2] || mem_wr_en !== 1'b0) begin
        failures++; $display("FAIL t3_solo_%0d got=%b rd=%b wr=%b exp=%b rd=%b wr=0", k, gnt, mem_rd_en, mem_wr_en, exp, exp[2]); end
    end
    req = '0;
    step();
    step();
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_req(0, 1'b1, 2'd0, 8'h11);
    step();
    req[0] = 1'b0;
    step();
    set_req(0, 1'b1, 2'd1, 8'h22);
    step();
    req[0] = 1'b0;
    step();
    set_req(1, 1'b0, 2'd0, 8'h00);
    set_req(3, 1'b0, 2'd1, 8'h00);
    step();
    checks++; if ({gnt, mem_rd_en, mem_addr} !== {4'b0010, 1'b1, 2'd0}) begin
      failures++; $display("FAIL t4_issue1 got=%b %b %h exp=0010 1 0", gnt, mem_rd_en, mem_addr); end
    req[1] = 1'b0;
    step();
    checks++; if ({gnt, mem_rd_en, mem_addr} !== {4'b1000, 1'b1, 2'd1}) begin
      failures++; $display("FAIL t4_issue3 got=%b %b %h exp=1000 1 1", gnt, mem_rd_en, mem_addr); end
    req[3] = 1'b0;
    step();
    checks++; if (rsp_valid !== 4'b0010 || rsp_rdata !== 8'h11) begin
      failures++; $display("FAIL t4_rsp1 got=%b/%h exp=0010/11", rsp_valid, rsp_rdata); end
    step();
    checks++; if (rsp_valid !== 4'b1000 || rsp_rdata !== 8'h22) begin
      failures++; $display("FAIL t4_rsp3 got=%b/%h exp=1000/22", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_reset_mid_read();
    set_req(0, 1'b0, 2'd2, 8'h5A);
    step();
    checks++; if (gnt !== 4'b0001 || mem_rd_en !== 1'b1) begin
      failures++; $display("FAIL t5_gnt0 got=%b rd=%b exp=0001 rd=1", gnt, mem_rd_en); end
    req[0] = 1'b0;
    step();
    reset = 1'b1;
    step();
    checks++; if ({gnt, rsp_valid, mem_wr_en, mem_rd_en} !== 10'b0) begin
      failures++; $display("FAIL t5_rst_ctl got=%b %b %b%b exp=0", gnt, rsp_valid, mem_wr_en, mem_rd_en); end
    checks++; if ({mem_addr, mem_wdata, rsp_rdata} !== 18'h0) begin
      failures++; $display("FAIL t5_rst_data got=%h %h %h exp=0 00 00", mem_addr, mem_wdata, rsp_rdata); end
    reset = 1'b0;
    set_req(1, 1'b1, 2'd0, 8'h77);
    set_req(2, 1'b1, 2'd1, 8'h88);
    step();
    checks++; if (gnt !== 4'b0010 || rsp_valid !== 4'b0000) begin
      failures++; $display("FAIL t5_first got=%b rsp=%b exp=0010 rsp=0000", gnt, rsp_valid); end
    req[1] = 1'b0;
    step();
    checks++; if (gnt !== 4'b0100 || rsp_valid !== 4'b0000) begin
      failures++; $display("FAIL t5_second got=%b rsp=%b exp=0100 rsp=0000", gnt, rsp_valid); end
    req[2] = 1'b0;
    step();
    checks++; if (gnt !== 4'b0000 || rsp_valid !== 4'b0000) begin
      failures++; $display("FAIL t5_quiet got=%b rsp=%b exp=0000 rsp=0000", gnt, rsp_valid); end
  endtask

  task automatic test_raw();
    do_reset();
    set_req(0, 1'b1, 2'd3, 8'h3C);
    set_req(1, 1'b0, 2'd3, 8'h00);
    step();
    checks++; if ({gnt, mem_wr_en, mem_addr, mem_wdata} !== {4'b0001, 1'b1, 2'd3, 8'h3C}) begin
      failures++; $display("FAIL t6_wr got=%b %b %h %h exp=0001 1 3 3c", gnt, mem_wr_en, mem_addr, mem_wdata); end
    req[0] = 1'b0;
    step();
    checks++; if ({gnt, mem_rd_en, mem_wr_en, mem_addr} !== {4'b0010, 1'b1, 1'b0, 2'd3}) begin
      failures++; $display("FAIL t6_rd got=%b %b%b %h exp=0010 10 3", gnt, mem_rd_en, mem_wr_en, mem_addr); end
    req[1] = 1'b0;
    step();
    step();
    checks++; if (rsp_valid !== 4'b0010 || rsp_rdata !== 8'h3C) begin
      failures++; $display("FAIL t6_rsp got=%b/%h exp=0010/3c", rsp_valid, rsp_rdata); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    mem_rdata = '0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    test_reset();
    test_write_read();
    test_all_request();
    test_single_requester();
    test_back_to_back();
    test_reset_mid_read();
    test_raw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
